// File: rtl/pp_pipeline_accel_udiv_pkg.sv
// Shared types and widths for the 24/12 iterative restoring divider.
package pp_pipeline_accel_udiv_pkg;
  localparam int N     = 24;
  localparam int M     = 12;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/pp_pipeline_accel_udiv_step.sv
// One restoring-division step: shift one dividend bit into the partial remainder,
// subtract the divisor when it fits, and report the resulting quotient bit.
module pp_pipeline_accel_udiv_step
  import pp_pipeline_accel_udiv_pkg::*;
#(
  parameter int W = M
) (
  input  logic [W-1:0] partial,
  input  logic         shift_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] next_partial,
  output logic         qbit
);
  logic [W:0] trial;

  assign trial = {partial, shift_bit};
  assign qbit  = (trial >= {1'b0, divisor});
  // partial < divisor on entry, so the restored or subtracted value always fits W bits.
  assign next_partial = qbit ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
endmodule

// File: rtl/pp_pipeline_accel_udiv_24ns_12ns_seq.sv
// Iterative unsigned divider, one quotient bit per enabled cycle, with
// valid/ready handshakes on operands and results and a global clock enable.
module pp_pipeline_accel_udiv_24ns_12ns_seq
  import pp_pipeline_accel_udiv_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = N,
  parameter int DIVISOR_WIDTH  = M
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      din_vld,
  output logic                      din_rdy,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      dout_vld,
  input  logic                      dout_rdy,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div0
);
  localparam int CW = $clog2(DIVIDEND_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDEND_WIDTH - 1);

  state_t                    state_reg;
  logic                      din_rdy_reg;
  logic                      dout_vld_reg;
  logic                      div0_reg;
  logic [CW-1:0]             cnt_reg;
  logic [DIVIDEND_WIDTH-1:0] dq_reg;
  logic [DIVIDEND_WIDTH-1:0] quotient_reg;
  logic [DIVISOR_WIDTH-1:0]  rem_reg;
  logic [DIVISOR_WIDTH-1:0]  divisor_reg;
  logic [DIVISOR_WIDTH-1:0]  remainder_reg;
  logic [DIVISOR_WIDTH-1:0]  step_rem;
  logic                      step_qbit;

  pp_pipeline_accel_udiv_step #(
    .W(DIVISOR_WIDTH)
  ) u_step (
    .partial     (rem_reg),
    .shift_bit   (dq_reg[DIVIDEND_WIDTH-1]),
    .divisor     (divisor_reg),
    .next_partial(step_rem),
    .qbit        (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      din_rdy_reg   <= 1'b1;
      dout_vld_reg  <= 1'b0;
      div0_reg      <= 1'b0;
      cnt_reg       <= '0;
      dq_reg        <= '0;
      quotient_reg  <= '0;
      rem_reg       <= '0;
      divisor_reg   <= '0;
      remainder_reg <= '0;
    end else if (ce) begin
      case (state_reg)
        S_IDLE: begin
          if (din_vld) begin
            dq_reg      <= dividend;
            divisor_reg <= divisor;
            rem_reg     <= '0;
            cnt_reg     <= CNT_LAST;
            din_rdy_reg <= 1'b0;
            state_reg   <= S_RUN;
          end
        end
        S_RUN: begin
          // Zero divisor skips the iterations; the dividend is still intact in dq_reg.
          if (divisor_reg == '0) begin
            quotient_reg  <= '1;
            remainder_reg <= dq_reg[DIVISOR_WIDTH-1:0];
            div0_reg      <= 1'b1;
            dout_vld_reg  <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            rem_reg <= step_rem;
            dq_reg  <= {dq_reg[DIVIDEND_WIDTH-2:0], step_qbit};
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
              quotient_reg  <= {dq_reg[DIVIDEND_WIDTH-2:0], step_qbit};
              remainder_reg <= step_rem;
              div0_reg      <= 1'b0;
              dout_vld_reg  <= 1'b1;
              state_reg     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (dout_rdy) begin
            dout_vld_reg <= 1'b0;
            din_rdy_reg  <= 1'b1;
            state_reg    <= S_IDLE;
          end
        end
        default: begin
          dout_vld_reg <= 1'b0;
          din_rdy_reg  <= 1'b1;
          state_reg    <= S_IDLE;
        end
      endcase
    end
  end

  assign din_rdy   = din_rdy_reg;
  assign dout_vld  = dout_vld_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div0      = div0_reg;
endmodule
